// File: rtl/amo_arbiter.sv
// ---------------------------------------------------------------------------
// amo_arbiter
//   Shares the single D$ AMO port between NR_PORTS AMO requesters.
//   Round-robin grant, one AMO in flight. The granted request is snapshotted
//   into an output register and held until the cache acks; the ack/result is
//   routed back to the owning port only.
//
// Ports
//   clk_i       in   clock
//   rst_i       in   synchronous reset, active-high
//   amo_req_i   in   per-port AMO request (.req held until own ack)
//   amo_resp_o  out  per-port response (ack, result), result gated by ack
//   amo_req_o   out  registered request to the D$
//   amo_resp_i  in   response from the D$
//   busy_o      out  an AMO is outstanding
//   spurious_o  out  sticky: ack seen while idle, cleared by reset only
// ---------------------------------------------------------------------------
package ariane_pkg;
  typedef enum logic [3:0] {
    AMO_NONE, AMO_LR, AMO_SC, AMO_SWAP, AMO_ADD, AMO_AND, AMO_OR,
    AMO_XOR, AMO_MAX, AMO_MAXU, AMO_MIN, AMO_MINU, AMO_CAS1, AMO_CAS2
  } amo_t;

  typedef struct packed {
    logic        req;
    amo_t        amo_op;
    logic [1:0]  size;
    logic [63:0] operand_a;
    logic [63:0] operand_b;
  } amo_req_t;

  typedef struct packed {
    logic        ack;
    logic [63:0] result;
  } amo_resp_t;
endpackage

module amo_arbiter #(
  parameter int unsigned NR_PORTS = 2
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  ariane_pkg::amo_req_t  [NR_PORTS-1:0]  amo_req_i,
  output ariane_pkg::amo_resp_t [NR_PORTS-1:0]  amo_resp_o,
  output ariane_pkg::amo_req_t                  amo_req_o,
  input  ariane_pkg::amo_resp_t                 amo_resp_i,
  output logic                                  busy_o,
  output logic                                  spurious_o
);
  localparam int unsigned IDX_W = $clog2(NR_PORTS);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state_reg, state_next;
  logic [IDX_W-1:0]     rr_ptr_reg, rr_ptr_next;
  logic [IDX_W-1:0]     sel_reg, sel_next;
  ariane_pkg::amo_req_t req_reg, req_next;
  logic                 spurious_reg, spurious_next;

  logic [IDX_W-1:0]     win_idx;
  logic                 win_valid;
  logic [IDX_W:0]       cand;

  // Rotating priority scan starting at rr_ptr. cand is one bit wider than an
  // index so rr_ptr + offset can be folded back below NR_PORTS even when
  // NR_PORTS is not a power of two.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NR_PORTS; i++) begin
      cand = {1'b0, rr_ptr_reg} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NR_PORTS)) begin
        cand = cand - (IDX_W+1)'(NR_PORTS);
      end
      if (!win_valid && amo_req_i[cand[IDX_W-1:0]].req) begin
        win_valid = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // Next-state logic. No grant is evaluated in BUSY, so the ack cycle can
  // never issue a new request: an idle cycle always separates two AMOs.
  always_comb begin
    state_next    = state_reg;
    rr_ptr_next   = rr_ptr_reg;
    sel_next      = sel_reg;
    req_next      = req_reg;
    spurious_next = spurious_reg;
    case (state_reg)
      IDLE: begin
        if (amo_resp_i.ack) begin
          spurious_next = 1'b1;
        end
        if (win_valid) begin
          state_next   = BUSY;
          sel_next     = win_idx;
          req_next     = amo_req_i[win_idx];
          req_next.req = 1'b1;
        end
      end
      BUSY: begin
        // A requester withdrawing .req does not cancel: the D$ op completes.
        if (amo_resp_i.ack) begin
          state_next   = IDLE;
          req_next.req = 1'b0;
          rr_ptr_next  = (sel_reg == IDX_W'(NR_PORTS - 1)) ? '0
                                                           : sel_reg + IDX_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= IDLE;
      rr_ptr_reg   <= '0;
      sel_reg      <= '0;
      req_reg      <= '0;
      spurious_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rr_ptr_reg   <= rr_ptr_next;
      sel_reg      <= sel_next;
      req_reg      <= req_next;
      spurious_reg <= spurious_next;
    end
  end

  // Response routing: only the owning port sees the ack, and result is
  // forced to zero whenever ack is low.
  generate
    for (genvar gi = 0; gi < NR_PORTS; gi++) begin : g_resp
      always_comb begin
        amo_resp_o[gi] = '0;
        if (state_reg == BUSY && amo_resp_i.ack && sel_reg == IDX_W'(gi)) begin
          amo_resp_o[gi].ack    = 1'b1;
          amo_resp_o[gi].result = amo_resp_i.result;
        end
      end
    end
  endgenerate

  assign amo_req_o  = req_reg;
  assign busy_o     = (state_reg == BUSY);
  assign spurious_o = spurious_reg;

endmodule

// File: tb/tb_amo_arbiter.sv
// Testbench for amo_arbiter: directed scenarios plus a randomized run, with
// a transaction-level reference model (owner index, round-robin pointer as
// plain integers, modular scan) for a 2-port and a 3-port instance.
module tb_amo_arbiter;
  import ariane_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  amo_req_t  [1:0] req2;
  amo_resp_t [1:0] resp2_o;
  amo_req_t        out2;
  amo_resp_t       resp2_i;
  logic            busy2, spur2;

  amo_req_t  [2:0] req3;
  amo_resp_t [2:0] resp3_o;
  amo_req_t        out3;
  amo_resp_t       resp3_i;
  logic            busy3, spur3;

  amo_arbiter #(.NR_PORTS(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .amo_req_i(req2), .amo_resp_o(resp2_o),
    .amo_req_o(out2), .amo_resp_i(resp2_i), .busy_o(busy2), .spurious_o(spur2)
  );

  amo_arbiter #(.NR_PORTS(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .amo_req_i(req3), .amo_resp_o(resp3_o),
    .amo_req_o(out3), .amo_resp_i(resp3_i), .busy_o(busy3), .spurious_o(spur3)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  bit       m_busy  [2];
  int       m_owner [2];
  int       m_rr    [2];
  amo_req_t m_lat   [2];
  bit       m_spur  [2];

  function automatic int nports(input int d);
    return (d == 0) ? 2 : 3;
  endfunction

  function automatic amo_req_t get_req(input int d, input int k);
    return (d == 0) ? req2[k[0]] : req3[k[1:0]];
  endfunction

  function automatic amo_resp_t get_rsp(input int d);
    return (d == 0) ? resp2_i : resp3_i;
  endfunction

  function automatic amo_resp_t get_out_resp(input int d, input int k);
    return (d == 0) ? resp2_o[k[0]] : resp3_o[k[1:0]];
  endfunction

  function automatic amo_resp_t model_resp(input int d, input int k);
    amo_resp_t r = '0;
    if (m_busy[d] && get_rsp(d).ack && m_owner[d] == k) begin
      r.ack    = 1'b1;
      r.result = get_rsp(d).result;
    end
    return r;
  endfunction

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      int n = nports(d);
      if (rst) begin
        m_busy[d] = 0; m_owner[d] = 0; m_rr[d] = 0; m_lat[d] = '0; m_spur[d] = 0;
      end else if (m_busy[d]) begin
        if (get_rsp(d).ack) begin
          m_busy[d]    = 0;
          m_rr[d]      = (m_owner[d] + 1) % n;
          m_lat[d].req = 1'b0;
        end
      end else begin
        bit done = 0;
        if (get_rsp(d).ack) m_spur[d] = 1;
        for (int i = 0; i < n; i++) begin
          int k = (m_rr[d] + i) % n;
          if (!done && get_req(d, k).req) begin
            done         = 1;
            m_busy[d]    = 1;
            m_owner[d]   = k;
            m_lat[d]     = get_req(d, k);
            m_lat[d].req = 1'b1;
          end
        end
      end
    end
  endtask

  // Advance one clock; inputs are driven after negedge, outputs sampled at negedge.
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic amo_req_t mk_req(input amo_t op, input logic [63:0] a,
                                      input logic [63:0] b);
    amo_req_t r;
    r.req = 1'b1; r.amo_op = op; r.size = 2'b11; r.operand_a = a; r.operand_b = b;
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b1; req2 = '0; req3 = '0; resp2_i = '0; resp3_i = '0;
    tick();
    rst = 1'b0;
  endtask

  // ---------------- directed tests ----------------
  task automatic test_reset();
    rst = 1'b1; req2 = '0; req3 = '0; resp2_i = '0; resp3_i = '0;
    tick(); tick();
    rst = 1'b0;
    checks++; if (out2 !== '0) begin errors++; $display("FAIL reset_req2: got %h expected 0", out2); end
    checks++; if (out3 !== '0) begin errors++; $display("FAIL reset_req3: got %h expected 0", out3); end
    checks++; if (busy2 !== 1'b0 || busy3 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b%b expected 00", busy2, busy3); end
    checks++; if (spur2 !== 1'b0 || spur3 !== 1'b0) begin errors++; $display("FAIL reset_spur: got %b%b expected 00", spur2, spur3); end
    checks++; if (resp2_o !== '0 || resp3_o !== '0) begin errors++; $display("FAIL reset_resp: got %h %h expected 0", resp2_o, resp3_o); end
    $display("test_reset done");
  endtask

  task automatic test_single();
    amo_req_t exp;
    do_reset();
    exp = mk_req(AMO_ADD, 64'h8000_0010, 64'd5);
    req2[0] = exp;
    #1;
    checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL single_no_early_grant: got %b expected 0", busy2); end
    tick();
    checks++; if (out2 !== exp) begin errors++; $display("FAIL single_grant: got %h expected %h", out2, exp); end
    tick(); tick();
    checks++; if (out2 !== exp) begin errors++; $display("FAIL single_hold: got %h expected %h", out2, exp); end
    resp2_i.ack = 1'b1; resp2_i.result = 64'h1234_5678_9abc_def0; req2[0].req = 1'b0;
    #1;
    checks++; if (resp2_o[0].ack !== 1'b1 || resp2_o[0].result !== 64'h1234_5678_9abc_def0) begin
      errors++; $display("FAIL single_ack0: got %h expected 11234_5678_9abc_def0", resp2_o[0]); end
    checks++; if (resp2_o[1] !== '0) begin errors++; $display("FAIL single_ack1: got %h expected 0", resp2_o[1]); end
    tick();
    resp2_i = '0;
    checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL single_idle: got %b expected 0", busy2); end
    // rr_ptr now 1: port 1 must beat port 0
    req2[0] = mk_req(AMO_OR, 64'hA0, 64'd1);
    req2[1] = mk_req(AMO_XOR, 64'hB1, 64'd2);
    tick();
    checks++; if (out2.operand_a !== 64'hB1) begin errors++; $display("FAIL single_rr: got %h expected b1", out2.operand_a); end
    resp2_i.ack = 1'b1; req2[1].req = 1'b0;
    tick();
    resp2_i = '0; req2 = '0;
    $display("test_single done");
  endtask

  task automatic test_round_robin();
    int expect_order[4] = '{0, 1, 0, 1};
    do_reset();
    req2[0] = mk_req(AMO_ADD, 64'd0, 64'd10);
    req2[1] = mk_req(AMO_ADD, 64'd1, 64'd11);
    for (int g = 0; g < 4; g++) begin
      tick();
      checks++; if (busy2 !== 1'b1 || out2.operand_a !== 64'(expect_order[g])) begin
        errors++; $display("FAIL rr_order[%0d]: got busy=%b port=%0d expected port=%0d", g, busy2, out2.operand_a, expect_order[g]); end
      tick();
      resp2_i.ack = 1'b1; resp2_i.result = 64'(g + 100);
      #1;
      checks++; if (resp2_o[expect_order[g]].ack !== 1'b1 || resp2_o[1 - expect_order[g]] !== '0) begin
        errors++; $display("FAIL rr_route[%0d]: got %h expected ack on port %0d", g, resp2_o, expect_order[g]); end
      tick();
      resp2_i = '0;
      checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL rr_gap[%0d]: got %b expected 0", g, busy2); end
    end
    req2 = '0;
    $display("test_round_robin done");
  endtask

  task automatic test_wrap3();
    do_reset();
    req3[2] = mk_req(AMO_SWAP, 64'd2, 64'd9);
    for (int r = 0; r < 3; r++) begin
      tick();
      checks++; if (busy3 !== 1'b1 || out3.operand_a !== 64'd2) begin
        errors++; $display("FAIL wrap3_grant[%0d]: got busy=%b a=%h expected busy=1 a=2", r, busy3, out3.operand_a); end
      resp3_i.ack = 1'b1; resp3_i.result = 64'(r + 7);
      #1;
      checks++; if (resp3_o[2].ack !== 1'b1 || resp3_o[2].result !== 64'(r + 7) || resp3_o[0] !== '0 || resp3_o[1] !== '0) begin
        errors++; $display("FAIL wrap3_route[%0d]: got %h expected ack on port 2 result %0d", r, resp3_o, r + 7); end
      tick();
      resp3_i = '0;
      checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL wrap3_gap[%0d]: got %b expected 0", r, busy3); end
    end
    req3 = '0;
    $display("test_wrap3 done");
  endtask

  task automatic test_withdraw();
    amo_req_t exp;
    do_reset();
    exp = mk_req(AMO_AND, 64'h100, 64'd7);
    req2[0] = exp;
    tick();
    checks++; if (out2 !== exp) begin errors++; $display("FAIL withdraw_grant: got %h expected %h", out2, exp); end
    req2[0].req = 1'b0; req2[0].operand_b = 64'h999;
    req2[1] = mk_req(AMO_MAX, 64'h200, 64'd3);
    tick(); tick();
    checks++; if (out2 !== exp || busy2 !== 1'b1) begin errors++; $display("FAIL withdraw_hold: got %h expected %h", out2, exp); end
    resp2_i.ack = 1'b1; resp2_i.result = 64'h55;
    #1;
    checks++; if (resp2_o[0].ack !== 1'b1 || resp2_o[0].result !== 64'h55 || resp2_o[1] !== '0) begin
      errors++; $display("FAIL withdraw_route: got %h expected ack on port 0 result 55", resp2_o); end
    tick();
    resp2_i = '0;
    checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL withdraw_gap: got %b expected 0", busy2); end
    tick();
    checks++; if (busy2 !== 1'b1 || out2.operand_a !== 64'h200) begin
      errors++; $display("FAIL withdraw_next: got a=%h expected 200", out2.operand_a); end
    resp2_i.ack = 1'b1; req2[1].req = 1'b0;
    tick();
    resp2_i = '0; req2 = '0;
    $display("test_withdraw done");
  endtask

  task automatic test_spurious();
    do_reset();
    resp2_i.ack = 1'b1; resp2_i.result = 64'hDEAD;
    resp3_i.ack = 1'b1; resp3_i.result = 64'hDEAD;
    #1;
    checks++; if (resp2_o !== '0 || resp3_o !== '0) begin errors++; $display("FAIL spur_route: got %h %h expected 0", resp2_o, resp3_o); end
    tick();
    resp2_i = '0; resp3_i = '0;
    checks++; if (spur2 !== 1'b1 || spur3 !== 1'b1) begin errors++; $display("FAIL spur_set: got %b%b expected 11", spur2, spur3); end
    tick(); tick();
    checks++; if (spur2 !== 1'b1 || spur3 !== 1'b1) begin errors++; $display("FAIL spur_sticky: got %b%b expected 11", spur2, spur3); end
    $display("test_spurious done");
  endtask

  task automatic test_reset_busy();
    // Complete one AMO on port 0 so rr_ptr becomes 1, then grant again and reset.
    req2[0] = mk_req(AMO_MIN, 64'h300, 64'd1);
    tick();
    resp2_i.ack = 1'b1;
    tick();
    resp2_i = '0;
    req2[1] = mk_req(AMO_MINU, 64'h301, 64'd4);
    tick();
    checks++; if (busy2 !== 1'b1) begin errors++; $display("FAIL rstbusy_pre: got %b expected 1", busy2); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (out2 !== '0 || busy2 !== 1'b0) begin errors++; $display("FAIL rstbusy_clear: got %h busy=%b expected 0", out2, busy2); end
    checks++; if (spur2 !== 1'b0) begin errors++; $display("FAIL rstbusy_spur: got %b expected 0", spur2); end
    // Both still requesting: rr_ptr back at 0, so port 0 wins first.
    tick();
    checks++; if (busy2 !== 1'b1 || out2.operand_a !== 64'h300) begin
      errors++; $display("FAIL rstbusy_rr0: got a=%h expected 300", out2.operand_a); end
    resp2_i.ack = 1'b1; req2[0].req = 1'b0;
    tick();
    resp2_i = '0;
    tick();
    checks++; if (busy2 !== 1'b1 || out2.operand_a !== 64'h301) begin
      errors++; $display("FAIL rstbusy_port1: got a=%h expected 301", out2.operand_a); end
    resp2_i.ack = 1'b1; req2[1].req = 1'b0;
    tick();
    resp2_i = '0; req2 = '0;
    $display("test_reset_busy done");
  endtask

  // ---------------- randomized test against the model ----------------
  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int d = 0; d < 2; d++) begin
        amo_resp_t rs;
        rs.ack    = m_busy[d] ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 59) == 0);
        rs.result = {$urandom, $urandom};
        if (d == 0) resp2_i = rs; else resp3_i = rs;
        for (int k = 0; k < nports(d); k++) begin
          amo_req_t r = get_req(d, k);
          bit owner = m_busy[d] && (m_owner[d] == k);
          if (!r.req) begin
            if ($urandom_range(0, 2) == 0) begin
              r.req = 1'b1; r.amo_op = amo_t'($urandom_range(0, 13)); r.size = 2'($urandom);
              r.operand_a = {$urandom, $urandom}; r.operand_b = {$urandom, $urandom};
            end
          end else if (owner && rs.ack) begin
            if ($urandom_range(0, 3) != 0) r.req = 1'b0;
          end else if (owner) begin
            if ($urandom_range(0, 15) == 0) r.req = 1'b0;
            if ($urandom_range(0, 3) == 0) r.operand_b = {$urandom, $urandom};
          end
          if (d == 0) req2[k[0]] = r; else req3[k[1:0]] = r;
        end
      end
      #1;
      for (int d = 0; d < 2; d++) begin
        for (int k = 0; k < nports(d); k++) begin
          checks++; if (get_out_resp(d, k) !== model_resp(d, k)) begin
            errors++; $display("FAIL rand_resp d%0d p%0d cyc%0d: got %h expected %h", d, k, cyc, get_out_resp(d, k), model_resp(d, k)); end
        end
      end
      tick();
      checks++; if (busy2 !== m_busy[0] || busy3 !== m_busy[1]) begin
        errors++; $display("FAIL rand_busy cyc%0d: got %b%b expected %b%b", cyc, busy2, busy3, m_busy[0], m_busy[1]); end
      checks++; if (spur2 !== m_spur[0] || spur3 !== m_spur[1]) begin
        errors++; $display("FAIL rand_spur cyc%0d: got %b%b expected %b%b", cyc, spur2, spur3, m_spur[0], m_spur[1]); end
      checks++; if (out2.req !== m_busy[0] || (m_busy[0] && out2 !== m_lat[0])) begin
        errors++; $display("FAIL rand_req2 cyc%0d: got %h expected %h", cyc, out2, m_lat[0]); end
      checks++; if (out3.req !== m_busy[1] || (m_busy[1] && out3 !== m_lat[1])) begin
        errors++; $display("FAIL rand_req3 cyc%0d: got %h expected %h", cyc, out3, m_lat[1]); end
    end
    resp2_i = '0; resp3_i = '0; req2 = '0; req3 = '0;
    $display("test_random done");
  endtask

  initial begin
    rst = 1'b1; req2 = '0; req3 = '0; resp2_i = '0; resp3_i = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_wrap3();
    test_withdraw();
    test_spurious();
    test_reset_busy();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
